// File: rtl/pixel_wr_packer.sv
`timescale 1ns/1ps
// pixel_wr_packer
// Packs 32-bit pixel words into 128-bit beats, keeps one complete beat
// pending, and hands it to the DDR3 write stage through a single-request
// handshake. Beat addresses step through a frame buffer region and wrap
// at the end of each frame.
module pixel_wr_packer #(
    parameter logic [25:0] BASE_ADDR   = 26'd0,
    parameter int unsigned FRAME_BEATS = 76800
) (
    input  logic         ddr3_clk,
    input  logic         reset_n,
    input  logic         frame_start,
    input  logic [31:0]  pix_data,
    input  logic         pix_valid,
    output logic         pix_ready,
    output logic         wr_req,
    output logic [25:0]  wr_addr,
    output logic [127:0] wr_data,
    input  logic         wr_done,
    output logic         frame_done
);

    localparam logic [25:0] LAST_OFFSET = 26'(FRAME_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     pack_cnt_q, pack_cnt_d;
    logic [95:0]    pack_q, pack_d;
    logic [25:0]    offset_q, offset_d;
    logic           pend_valid_q, pend_valid_d;
    logic           pend_last_q, pend_last_d;
    logic [25:0]    pend_addr_q, pend_addr_d;
    logic [127:0]   pend_data_q, pend_data_d;
    logic           frame_done_q, frame_done_d;
    logic           accept;
    logic           beat_done;

    // Stall only when a beat is already pending and the pack holds 3 words,
    // i.e. the next word would need a second pending slot. Register-only.
    assign pix_ready  = !(pend_valid_q && (pack_cnt_q == 2'd3));
    assign accept     = pix_valid && pix_ready;
    assign wr_req     = (state_q == ST_ISSUE);
    assign wr_addr    = pend_addr_q;
    assign wr_data    = pend_data_q;
    assign frame_done = frame_done_q;

    // Pack incoming words, promote a full line to the pending slot, and
    // handle frame restart (which only touches the pack and the offset).
    always_comb begin
        pack_d       = pack_q;
        pack_cnt_d   = pack_cnt_q;
        offset_d     = offset_q;
        pend_valid_d = pend_valid_q;
        pend_last_d  = pend_last_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;

        // A pending beat only retires here; a new line can never be loaded
        // in the same cycle because loading needs pend_valid_q low.
        if (beat_done) begin
            pend_valid_d = 1'b0;
        end

        if (frame_start) begin
            // Restart wins over completing a line: the word is word 0.
            pack_cnt_d = 2'd0;
            offset_d   = '0;
            if (accept) begin
                pack_d[31:0] = pix_data;
                pack_cnt_d   = 2'd1;
            end
        end else if (accept) begin
            case (pack_cnt_q)
                2'd0: begin
                    pack_d[31:0] = pix_data;
                    pack_cnt_d   = 2'd1;
                end
                2'd1: begin
                    pack_d[63:32] = pix_data;
                    pack_cnt_d    = 2'd2;
                end
                2'd2: begin
                    pack_d[95:64] = pix_data;
                    pack_cnt_d    = 2'd3;
                end
                default: begin
                    pend_valid_d = 1'b1;
                    pend_data_d  = {pix_data, pack_q};
                    pend_addr_d  = BASE_ADDR + offset_q;
                    pend_last_d  = (offset_q == LAST_OFFSET);
                    pack_cnt_d   = 2'd0;
                    offset_d     = (offset_q == LAST_OFFSET) ? '0 : offset_q + 26'd1;
                end
            endcase
        end
    end

    // Issue FSM: one-cycle request per pending beat, then wait for completion.
    always_comb begin
        state_d      = state_q;
        beat_done    = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wr_done) begin
                    beat_done    = 1'b1;
                    frame_done_d = pend_last_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any beat in flight.
    always_ff @(posedge ddr3_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pack_cnt_q   <= 2'd0;
            pack_q       <= '0;
            offset_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_last_q  <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pack_cnt_q   <= pack_cnt_d;
            pack_q       <= pack_d;
            offset_q     <= offset_d;
            pend_valid_q <= pend_valid_d;
            pend_last_q  <= pend_last_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_pixel_wr_packer.sv
`timescale 1ns/1ps
// Bench for pixel_wr_packer: cycle table, directed multi-cycle sequences
// and a randomized run against a queue-based reference model.
module tb_pixel_wr_packer;

    localparam logic [25:0] BASE = 26'h3FFFFFE;
    localparam int          FB   = 3;

    logic         ddr3_clk = 1'b0;
    logic         reset_n;
    logic         frame_start;
    logic [31:0]  pix_data;
    logic         pix_valid;
    logic         pix_ready;
    logic         wr_req;
    logic [25:0]  wr_addr;
    logic [127:0] wr_data;
    logic         wr_done;
    logic         frame_done;

    int n_vec = 0;
    int n_bad = 0;

    logic         s_pr, s_req, s_fd;
    logic [25:0]  s_addr;
    logic [127:0] s_data;

    always #5 ddr3_clk = ~ddr3_clk;

    pixel_wr_packer #(
        .BASE_ADDR  (BASE),
        .FRAME_BEATS(FB)
    ) dut (
        .ddr3_clk   (ddr3_clk),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_done    (wr_done),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic         fs;
        logic         pv;
        logic [31:0]  d;
        logic         wd;
        logic         e_pr;
        logic         e_req;
        logic         e_fd;
        logic         chk;
        logic [25:0]  e_addr;
        logic [127:0] e_data;
    } vec_t;

    typedef struct packed {
        logic [25:0]  addr;
        logic [127:0] data;
        logic         last;
        int           fc;
    } beat_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: bound expired or event out of place", name);
    endtask

    // Drive one cycle of inputs, sample outputs before the edge, advance.
    task automatic cyc(input logic fs, input logic pv, input logic [31:0] d, input logic wd);
        frame_start = fs;
        pix_valid   = pv;
        pix_data    = d;
        wr_done     = wd;
        #1;
        s_pr   = pix_ready;
        s_req  = wr_req;
        s_fd   = frame_done;
        s_addr = wr_addr;
        s_data = wr_data;
        @(negedge ddr3_clk);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = '0;
        wr_done     = 1'b0;
        #1;
        check("rst_pix_ready", 128'(pix_ready), 128'(1'b1));
        check("rst_wr_req", 128'(wr_req), 128'(1'b0));
        check("rst_frame_done", 128'(frame_done), 128'(1'b0));
        check("rst_wr_addr", 128'(wr_addr), 128'(26'd0));
        check("rst_wr_data", wr_data, 128'd0);
        @(negedge ddr3_clk);
        @(negedge ddr3_clk);
        reset_n = 1'b1;
    endtask

    // Cycle table: first beat latency, stall, wr_done ignored in IDLE/ISSUE.
    task automatic run_table();
        vec_t tbl[14];
        logic [127:0] b1, b2;
        b1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        b2 = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
        tbl[0]  = '{1'b0, 1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 128'd0};
        tbl[1]  = '{1'b0, 1'b1, 32'h22222222, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 128'd0};
        tbl[2]  = '{1'b0, 1'b1, 32'h33333333, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 128'd0};
        tbl[3]  = '{1'b0, 1'b1, 32'h44444444, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 128'd0};
        tbl[4]  = '{1'b0, 1'b1, 32'h55555555, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 128'd0};
        tbl[5]  = '{1'b0, 1'b1, 32'h66666666, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, BASE, b1};
        tbl[6]  = '{1'b0, 1'b1, 32'h77777777, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, BASE, b1};
        tbl[7]  = '{1'b0, 1'b1, 32'h88888888, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BASE, b1};
        tbl[8]  = '{1'b0, 1'b1, 32'h88888888, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BASE, b1};
        tbl[9]  = '{1'b0, 1'b1, 32'h88888888, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 128'd0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 128'd0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 26'h3FFFFFF, b2};
        tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 26'h3FFFFFF, b2};
        tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'd0, 128'd0};
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].fs, tbl[i].pv, tbl[i].d, tbl[i].wd);
            check($sformatf("tbl%0d_pix_ready", i), 128'(s_pr), 128'(tbl[i].e_pr));
            check($sformatf("tbl%0d_wr_req", i), 128'(s_req), 128'(tbl[i].e_req));
            check($sformatf("tbl%0d_frame_done", i), 128'(s_fd), 128'(tbl[i].e_fd));
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_wr_addr", i), 128'(s_addr), 128'(tbl[i].e_addr));
                check($sformatf("tbl%0d_wr_data", i), s_data, tbl[i].e_data);
            end
            $display("table row %0d: req=%0d ready=%0d addr=%h", i, s_req, s_pr, s_addr);
        end
    endtask

    // Hold wr_done low for 20 cycles while offering 8 words.
    task automatic seq_stall();
        int sent = 0;
        int reqs = 0;
        bit seen = 0;
        bit got2 = 0;
        logic [25:0]  a0 = '0;
        logic [127:0] d0 = '0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, sent < 8, 32'hA0000000 + 32'(sent), 1'b0);
            if (s_req) begin
                reqs++;
                a0   = s_addr;
                d0   = s_data;
                seen = 1;
            end else if (seen) begin
                check("stall_addr_hold", 128'(s_addr), 128'(a0));
                check("stall_data_hold", s_data, d0);
            end
            if (sent < 8 && s_pr) sent++;
        end
        check("stall_words_accepted", 128'(sent), 128'(7));
        check("stall_req_count", 128'(reqs), 128'(1));
        check("stall_ready_low", 128'(s_pr), 128'(1'b0));
        check("stall_first_addr", 128'(a0), 128'(BASE));
        check("stall_first_data", d0, {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000});
        cyc(1'b0, 1'b1, 32'hA0000007, 1'b1);
        check("stall_ready_at_done", 128'(s_pr), 128'(1'b0));
        for (int i = 0; i < 10 && !got2; i++) begin
            cyc(1'b0, sent < 8, 32'hA0000007, 1'b0);
            if (i == 0) check("stall_ready_after_done", 128'(s_pr), 128'(1'b1));
            if (sent < 8 && s_pr) sent++;
            if (s_req) begin
                got2 = 1;
                check("stall_second_addr", 128'(s_addr), 128'(26'h3FFFFFF));
                check("stall_second_data", s_data,
                      {32'hA0000007, 32'hA0000006, 32'hA0000005, 32'hA0000004});
                $display("stall second beat addr=%h", s_addr);
            end
        end
        if (!got2) flag("stall_second_req");
    endtask

    // Three-beat frame with prompt completions, then wrap to BASE.
    task automatic seq_frame3();
        logic [25:0] ea[4];
        int sent = 0, reqs = 0, fd_cnt = 0, fd_cyc = -1, nd = 0, timer = -1;
        int dc[4];
        logic wd;
        logic [31:0] w0;
        ea[0] = 26'h3FFFFFE;
        ea[1] = 26'h3FFFFFF;
        ea[2] = 26'h0000000;
        ea[3] = 26'h3FFFFFE;
        for (int i = 0; i < 100 && reqs < 4; i++) begin
            wd = (timer == 1);
            if (timer > 0) timer--;
            cyc(1'b0, sent < 16, 32'hB0000000 + 32'(sent), wd);
            if (wd && nd < 4) begin
                dc[nd] = i;
                nd++;
            end
            if (s_fd) begin
                fd_cnt++;
                fd_cyc = i;
            end
            check("f3_fd_req_exclusive", 128'(s_fd & s_req), 128'(1'b0));
            if (s_req) begin
                w0 = 32'hB0000000 + 32'(4 * reqs);
                check($sformatf("f3_addr%0d", reqs), 128'(s_addr), 128'(ea[reqs]));
                check($sformatf("f3_data%0d", reqs), s_data,
                      {w0 + 32'd3, w0 + 32'd2, w0 + 32'd1, w0});
                $display("frame3 beat %0d addr=%h", reqs, s_addr);
                reqs++;
                timer = 1;
            end
            if (sent < 16 && s_pr) sent++;
        end
        check("f3_req_count", 128'(reqs), 128'(4));
        check("f3_frame_done_count", 128'(fd_cnt), 128'(1));
        if (nd >= 3) check("f3_frame_done_cycle", 128'(fd_cyc), 128'(dc[2] + 1));
        else flag("f3_done_count");
    endtask

    // frame_start coincident with word 3 discards words 1..2.
    task automatic seq_frame_start();
        logic [31:0] fw[6];
        bit got = 0;
        fw[0] = 32'hC0000001;
        fw[1] = 32'hC0000002;
        fw[2] = 32'hC0000003;
        fw[3] = 32'hC0000004;
        fw[4] = 32'hC0000005;
        fw[5] = 32'hC0000006;
        for (int i = 0; i < 10; i++) begin
            cyc(i == 2, i < 6, fw[i % 6], 1'b0);
            if (s_req && !got) begin
                got = 1;
                check("fs_addr", 128'(s_addr), 128'(BASE));
                check("fs_data", s_data, {fw[5], fw[4], fw[3], fw[2]});
                $display("frame_start beat addr=%h data=%h", s_addr, s_data);
            end
        end
        if (!got) flag("fs_req");
    endtask

    // Reset asserted while a beat waits for completion.
    task automatic seq_reset_wait();
        bit got = 0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'hD0000000 + 32'(i), 1'b0);
        for (int i = 0; i < 6 && !got; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0);
            if (s_req) got = 1;
        end
        if (!got) flag("rw_req");
        reset_n = 1'b0;
        #1;
        check("rw_wr_req", 128'(wr_req), 128'(1'b0));
        check("rw_wr_addr", 128'(wr_addr), 128'(26'd0));
        check("rw_wr_data", wr_data, 128'd0);
        check("rw_frame_done", 128'(frame_done), 128'(1'b0));
        check("rw_pix_ready", 128'(pix_ready), 128'(1'b1));
        @(negedge ddr3_clk);
        reset_n = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0);
            check("rw_late_no_fd", 128'(s_fd), 128'(1'b0));
            check("rw_late_no_req", 128'(s_req), 128'(1'b0));
        end
    endtask

    // Random traffic against a word/beat queue model of the packer.
    task automatic run_random(input int ncyc);
        logic [31:0] part_q[$];
        beat_t       exp_q[$];
        beat_t       infl;
        beat_t       nb;
        bit          infl_v = 0;
        int          moff   = 0;
        int          timer  = -1;
        logic        exp_pr;
        logic        exp_fd = 1'b0;
        logic        fs, pv, wd;
        logic [31:0] d;
        infl = '0;
        for (int c = 0; c < ncyc; c++) begin
            wd = (timer == 1);
            if (timer > 0) timer--;
            fs = ($urandom_range(0, 49) == 0);
            pv = ($urandom_range(0, 3) != 0);
            d  = $urandom;
            frame_start = fs;
            pix_valid   = pv;
            pix_data    = d;
            wr_done     = wd;
            #1;
            exp_pr = !(((exp_q.size() != 0) || infl_v) && (part_q.size() == 3));
            check("rnd_pix_ready", 128'(pix_ready), 128'(exp_pr));
            check("rnd_frame_done", 128'(frame_done), 128'(exp_fd));
            if (infl_v) begin
                check("rnd_addr_hold", 128'(wr_addr), 128'(infl.addr));
                check("rnd_data_hold", wr_data, infl.data);
            end
            if (wr_req) begin
                if (exp_q.size() == 0 || infl_v) begin
                    flag("rnd_unexpected_wr_req");
                end else begin
                    infl   = exp_q.pop_front();
                    infl_v = 1;
                    check("rnd_req_latency", 128'(c - infl.fc), 128'(2));
                    check("rnd_wr_addr", 128'(wr_addr), 128'(infl.addr));
                    check("rnd_wr_data", wr_data, infl.data);
                    timer = $urandom_range(1, 4);
                    $display("rnd beat addr=%h data=%h last=%0d", wr_addr, wr_data, infl.last);
                end
            end else if (exp_q.size() != 0 && !infl_v && (c - exp_q[0].fc) >= 2) begin
                flag("rnd_missing_wr_req");
                void'(exp_q.pop_front());
            end
            exp_fd = 1'b0;
            if (wd && infl_v) begin
                exp_fd = infl.last;
                infl_v = 0;
            end
            if (fs) begin
                part_q.delete();
                moff = 0;
            end
            if (pv && exp_pr) begin
                part_q.push_back(d);
                if (part_q.size() == 4) begin
                    nb.addr = BASE + 26'(moff);
                    nb.data = {part_q[3], part_q[2], part_q[1], part_q[0]};
                    nb.last = (moff == FB - 1);
                    nb.fc   = c;
                    exp_q.push_back(nb);
                    part_q.delete();
                    moff = (moff + 1) % FB;
                end
            end
            @(negedge ddr3_clk);
        end
    endtask

    initial begin
        reset_n     = 1'b1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = '0;
        wr_done     = 1'b0;
        @(negedge ddr3_clk);
        do_reset();
        run_table();
        do_reset();
        seq_stall();
        do_reset();
        seq_frame3();
        do_reset();
        seq_frame_start();
        do_reset();
        seq_reset_wait();
        do_reset();
        run_random(3000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
